// File: rtl/mips_pkg.sv
// Shared MIPS datapath constants: widths, ALU op encodings, funct codes and ALU control codes.
package mips_pkg;

    localparam int XLEN_DEF  = 32;
    localparam int RADDR_DEF = 5;

    typedef enum logic [1:0] {
        ALU_OP_ADD   = 2'b00,
        ALU_OP_SUB   = 2'b01,
        ALU_OP_FUNCT = 2'b10,
        ALU_OP_OR    = 2'b11
    } alu_op_e;

    localparam logic [5:0] FUNCT_ADD = 6'b100000;
    localparam logic [5:0] FUNCT_SUB = 6'b100010;
    localparam logic [5:0] FUNCT_AND = 6'b100100;
    localparam logic [5:0] FUNCT_OR  = 6'b100101;
    localparam logic [5:0] FUNCT_SLT = 6'b101010;
    localparam logic [5:0] FUNCT_NOR = 6'b100111;

    localparam logic [3:0] ALU_AND = 4'b0000;
    localparam logic [3:0] ALU_OR  = 4'b0001;
    localparam logic [3:0] ALU_ADD = 4'b0010;
    localparam logic [3:0] ALU_SUB = 4'b0110;
    localparam logic [3:0] ALU_SLT = 4'b0111;
    localparam logic [3:0] ALU_NOR = 4'b1100;
    localparam logic [3:0] ALU_NOP = 4'b1111;

endpackage

// File: rtl/alu_ctrl_dec.sv
// Combinational ALU control decoder: alu_op plus R-type funct to the 4-bit ALU control code.
module alu_ctrl_dec
    import mips_pkg::*;
(
    input  logic [1:0] alu_op,
    input  logic [5:0] funct,
    output logic [3:0] alu_ctrl
);

    always_comb begin
        alu_ctrl = ALU_NOP;
        case (alu_op_e'(alu_op))
            ALU_OP_ADD: alu_ctrl = ALU_ADD;
            ALU_OP_SUB: alu_ctrl = ALU_SUB;
            ALU_OP_OR:  alu_ctrl = ALU_OR;
            ALU_OP_FUNCT: begin
                // Unknown funct maps to the code on which the ALU produces zero
                case (funct)
                    FUNCT_ADD: alu_ctrl = ALU_ADD;
                    FUNCT_SUB: alu_ctrl = ALU_SUB;
                    FUNCT_AND: alu_ctrl = ALU_AND;
                    FUNCT_OR:  alu_ctrl = ALU_OR;
                    FUNCT_SLT: alu_ctrl = ALU_SLT;
                    FUNCT_NOR: alu_ctrl = ALU_NOR;
                    default:   alu_ctrl = ALU_NOP;
                endcase
            end
            default: alu_ctrl = ALU_NOP;
        endcase
    end

endmodule

// File: rtl/id_ex_stage.sv
// ID/EX pipeline register with EX operand forwarding, ALU control decode and load-use hazard detection.
module id_ex_stage
    import mips_pkg::*;
#(
    parameter int XLEN  = XLEN_DEF,
    parameter int RADDR = RADDR_DEF
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             stall_i,
    input  logic             flush_i,
    input  logic             id_valid,
    input  logic [XLEN-1:0]  id_rs_data,
    input  logic [XLEN-1:0]  id_rt_data,
    input  logic [XLEN-1:0]  id_imm,
    input  logic [RADDR-1:0] id_rs,
    input  logic [RADDR-1:0] id_rt,
    input  logic [RADDR-1:0] id_rd,
    input  logic [5:0]       id_funct,
    input  logic [1:0]       id_alu_op,
    input  logic             id_alu_src,
    input  logic             id_reg_dst,
    input  logic             id_reg_write,
    input  logic             id_mem_read,
    input  logic             id_mem_write,
    input  logic             id_mem_to_reg,
    input  logic             id_branch_eq,
    input  logic             id_branch_neq,
    input  logic             exmem_reg_write,
    input  logic [RADDR-1:0] exmem_rd,
    input  logic [XLEN-1:0]  exmem_result,
    input  logic             memwb_reg_write,
    input  logic [RADDR-1:0] memwb_rd,
    input  logic [XLEN-1:0]  memwb_result,
    output logic [XLEN-1:0]  alu_a,
    output logic [XLEN-1:0]  alu_b,
    output logic [3:0]       alu_ctrl,
    output logic             alu_branch_eq,
    output logic             alu_branch_neq,
    output logic             ex_valid,
    output logic [RADDR-1:0] ex_wr_reg,
    output logic [XLEN-1:0]  ex_store_data,
    output logic             ex_reg_write,
    output logic             ex_mem_read,
    output logic             ex_mem_write,
    output logic             ex_mem_to_reg,
    output logic             hazard_stall_o
);

    logic [3:0]       dec_ctrl;
    logic [XLEN-1:0]  rs_data_q, rt_data_q, imm_q;
    logic [RADDR-1:0] rs_q, rt_q;
    logic             alu_src_q, branch_eq_q, branch_neq_q;
    logic [XLEN-1:0]  fwd_rs, fwd_rt;

    alu_ctrl_dec u_alu_ctrl_dec (
        .alu_op   (id_alu_op),
        .funct    (id_funct),
        .alu_ctrl (dec_ctrl)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n || flush_i) begin
            rs_data_q     <= '0;
            rt_data_q     <= '0;
            imm_q         <= '0;
            rs_q          <= '0;
            rt_q          <= '0;
            alu_src_q     <= 1'b0;
            branch_eq_q   <= 1'b0;
            branch_neq_q  <= 1'b0;
            alu_ctrl      <= 4'b0000;
            ex_valid      <= 1'b0;
            ex_wr_reg     <= '0;
            ex_reg_write  <= 1'b0;
            ex_mem_read   <= 1'b0;
            ex_mem_write  <= 1'b0;
            ex_mem_to_reg <= 1'b0;
        end else if (!stall_i) begin
            rs_data_q     <= id_rs_data;
            rt_data_q     <= id_rt_data;
            imm_q         <= id_imm;
            rs_q          <= id_rs;
            rt_q          <= id_rt;
            alu_src_q     <= id_alu_src;
            alu_ctrl      <= dec_ctrl;
            ex_wr_reg     <= id_reg_dst ? id_rd : id_rt;
            // A non-valid ID slot enters EX as a bubble with no side effects
            ex_valid      <= id_valid;
            branch_eq_q   <= id_branch_eq  & id_valid;
            branch_neq_q  <= id_branch_neq & id_valid;
            ex_reg_write  <= id_reg_write  & id_valid;
            ex_mem_read   <= id_mem_read   & id_valid;
            ex_mem_write  <= id_mem_write  & id_valid;
            ex_mem_to_reg <= id_mem_to_reg & id_valid;
        end
    end

    function automatic logic [XLEN-1:0] fwd_sel(
        input logic [RADDR-1:0] src,
        input logic [XLEN-1:0]  reg_val,
        input logic             em_we,
        input logic [RADDR-1:0] em_rd,
        input logic [XLEN-1:0]  em_val,
        input logic             mw_we,
        input logic [RADDR-1:0] mw_rd,
        input logic [XLEN-1:0]  mw_val
    );
        // The younger EX/MEM result takes precedence over MEM/WB
        if (em_we && (em_rd != '0) && (em_rd == src))
            return em_val;
        else if (mw_we && (mw_rd != '0) && (mw_rd == src))
            return mw_val;
        else
            return reg_val;
    endfunction

    assign fwd_rs = fwd_sel(rs_q, rs_data_q, exmem_reg_write, exmem_rd, exmem_result,
                            memwb_reg_write, memwb_rd, memwb_result);
    assign fwd_rt = fwd_sel(rt_q, rt_data_q, exmem_reg_write, exmem_rd, exmem_result,
                            memwb_reg_write, memwb_rd, memwb_result);

    assign alu_a          = fwd_rs;
    assign alu_b          = alu_src_q ? imm_q : fwd_rt;
    assign ex_store_data  = fwd_rt;
    assign alu_branch_eq  = branch_eq_q  & ex_valid;
    assign alu_branch_neq = branch_neq_q & ex_valid;

    assign hazard_stall_o = ex_valid & ex_mem_read & (ex_wr_reg != '0) &
                            ((ex_wr_reg == id_rs) | (ex_wr_reg == id_rt)) & id_valid;

endmodule

// File: tb/tb_id_ex_stage.sv
// Directed self-checking bench for id_ex_stage with hand-computed expected values.
module tb_id_ex_stage;

    logic        clk;
    logic        rst_n;
    logic        stall_i, flush_i, id_valid;
    logic [31:0] id_rs_data, id_rt_data, id_imm;
    logic [4:0]  id_rs, id_rt, id_rd;
    logic [5:0]  id_funct;
    logic [1:0]  id_alu_op;
    logic        id_alu_src, id_reg_dst, id_reg_write, id_mem_read, id_mem_write, id_mem_to_reg;
    logic        id_branch_eq, id_branch_neq;
    logic        exmem_reg_write, memwb_reg_write;
    logic [4:0]  exmem_rd, memwb_rd;
    logic [31:0] exmem_result, memwb_result;
    logic [31:0] alu_a, alu_b, ex_store_data;
    logic [3:0]  alu_ctrl;
    logic        alu_branch_eq, alu_branch_neq, ex_valid;
    logic [4:0]  ex_wr_reg;
    logic        ex_reg_write, ex_mem_read, ex_mem_write, ex_mem_to_reg, hazard_stall_o;

    int checks = 0;
    int errors = 0;

    id_ex_stage dut (
        .clk(clk), .rst_n(rst_n), .stall_i(stall_i), .flush_i(flush_i), .id_valid(id_valid),
        .id_rs_data(id_rs_data), .id_rt_data(id_rt_data), .id_imm(id_imm),
        .id_rs(id_rs), .id_rt(id_rt), .id_rd(id_rd), .id_funct(id_funct), .id_alu_op(id_alu_op),
        .id_alu_src(id_alu_src), .id_reg_dst(id_reg_dst), .id_reg_write(id_reg_write),
        .id_mem_read(id_mem_read), .id_mem_write(id_mem_write), .id_mem_to_reg(id_mem_to_reg),
        .id_branch_eq(id_branch_eq), .id_branch_neq(id_branch_neq),
        .exmem_reg_write(exmem_reg_write), .exmem_rd(exmem_rd), .exmem_result(exmem_result),
        .memwb_reg_write(memwb_reg_write), .memwb_rd(memwb_rd), .memwb_result(memwb_result),
        .alu_a(alu_a), .alu_b(alu_b), .alu_ctrl(alu_ctrl),
        .alu_branch_eq(alu_branch_eq), .alu_branch_neq(alu_branch_neq),
        .ex_valid(ex_valid), .ex_wr_reg(ex_wr_reg), .ex_store_data(ex_store_data),
        .ex_reg_write(ex_reg_write), .ex_mem_read(ex_mem_read), .ex_mem_write(ex_mem_write),
        .ex_mem_to_reg(ex_mem_to_reg), .hazard_stall_o(hazard_stall_o)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("[TB] FAIL watchdog timeout");
        $fatal(1, "[TB] simulation did not finish");
    end

    task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("[TB] FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    // Capture one ID slot and settle just past the edge
    task automatic applyStimulus();
        @(posedge clk);
        #1;
    endtask

    task automatic clearInputs();
        stall_i = 0; flush_i = 0; id_valid = 0;
        id_rs_data = 0; id_rt_data = 0; id_imm = 0;
        id_rs = 0; id_rt = 0; id_rd = 0; id_funct = 0; id_alu_op = 0;
        id_alu_src = 0; id_reg_dst = 0; id_reg_write = 0; id_mem_read = 0;
        id_mem_write = 0; id_mem_to_reg = 0; id_branch_eq = 0; id_branch_neq = 0;
        exmem_reg_write = 0; exmem_rd = 0; exmem_result = 0;
        memwb_reg_write = 0; memwb_rd = 0; memwb_result = 0;
    endtask

    logic [5:0] funct_tab [5] = '{6'b100000, 6'b100100, 6'b101010, 6'b100111, 6'b111111};
    logic [3:0] ctrl_tab  [5] = '{4'b0010,   4'b0000,   4'b0111,   4'b1100,   4'b1111};

    initial begin
        clearInputs();
        rst_n = 0;
        #2;
        checkOutput("reset_ex_valid", {31'b0, ex_valid}, 32'd0);
        checkOutput("reset_alu_ctrl", {28'b0, alu_ctrl}, 32'd0);
        #10 rst_n = 1;

        // R-type sub
        id_valid = 1; id_alu_op = 2'b10; id_funct = 6'b100010;
        id_rs = 5; id_rs_data = 32'h10; id_rt = 6; id_rt_data = 32'h3;
        id_rd = 9; id_reg_dst = 1; id_reg_write = 1;
        applyStimulus();
        checkOutput("sub_alu_ctrl", {28'b0, alu_ctrl}, 32'h6);
        checkOutput("sub_alu_a", alu_a, 32'h10);
        checkOutput("sub_alu_b", alu_b, 32'h3);
        checkOutput("sub_wr_reg", {27'b0, ex_wr_reg}, 32'd9);
        checkOutput("sub_valid", {31'b0, ex_valid}, 32'd1);
        checkOutput("sub_reg_write", {31'b0, ex_reg_write}, 32'd1);

        // Asynchronous reset in the middle of a cycle
        #2 rst_n = 0;
        #1;
        checkOutput("mid_rst_valid", {31'b0, ex_valid}, 32'd0);
        checkOutput("mid_rst_ctrl", {28'b0, alu_ctrl}, 32'd0);
        checkOutput("mid_rst_wr_reg", {27'b0, ex_wr_reg}, 32'd0);
        checkOutput("mid_rst_reg_write", {31'b0, ex_reg_write}, 32'd0);
        checkOutput("mid_rst_alu_a", alu_a, 32'd0);
        #1 rst_n = 1;
        clearInputs();

        // Funct decode table plus reg_dst=0 selecting rt
        for (int i = 0; i < 5; i++) begin
            id_valid = 1; id_alu_op = 2'b10; id_funct = funct_tab[i];
            id_rt = 5'(i + 1); id_rd = 5'd20; id_reg_dst = 0;
            applyStimulus();
            checkOutput($sformatf("funct_%0d_ctrl", i), {28'b0, alu_ctrl}, {28'b0, ctrl_tab[i]});
            checkOutput($sformatf("funct_%0d_wr_reg", i), {27'b0, ex_wr_reg}, 32'(i + 1));
        end
        id_alu_op = 2'b11;
        applyStimulus();
        checkOutput("op_or_ctrl", {28'b0, alu_ctrl}, 32'h1);
        id_alu_op = 2'b00;
        applyStimulus();
        checkOutput("op_add_ctrl", {28'b0, alu_ctrl}, 32'h2);

        // Forwarding priority on both operands
        clearInputs();
        id_valid = 1; id_rs = 7; id_rs_data = 32'h55; id_rt = 7; id_rt_data = 32'h66;
        applyStimulus();
        exmem_reg_write = 1; exmem_rd = 7; exmem_result = 32'hAA;
        memwb_reg_write = 1; memwb_rd = 7; memwb_result = 32'hBB;
        #1;
        checkOutput("fwd_exmem_a", alu_a, 32'hAA);
        checkOutput("fwd_exmem_b", alu_b, 32'hAA);
        exmem_rd = 0;
        #1;
        checkOutput("fwd_memwb_a", alu_a, 32'hBB);
        checkOutput("fwd_memwb_store", ex_store_data, 32'hBB);
        memwb_reg_write = 0;
        #1;
        checkOutput("fwd_none_a", alu_a, 32'h55);
        checkOutput("fwd_none_b", alu_b, 32'h66);

        // Register 0 is never forwarded
        clearInputs();
        id_valid = 1; id_rs = 0; id_rs_data = 32'h77;
        exmem_reg_write = 1; exmem_rd = 0; exmem_result = 32'hAA;
        memwb_reg_write = 1; memwb_rd = 0; memwb_result = 32'hBB;
        applyStimulus();
        checkOutput("reg0_alu_a", alu_a, 32'h77);

        // Load-use hazard then bubble insertion
        clearInputs();
        id_valid = 1; id_alu_op = 2'b00; id_alu_src = 1; id_mem_read = 1;
        id_reg_write = 1; id_mem_to_reg = 1; id_rt = 8; id_reg_dst = 0;
        applyStimulus();
        checkOutput("lw_mem_read", {31'b0, ex_mem_read}, 32'd1);
        checkOutput("lw_mem_to_reg", {31'b0, ex_mem_to_reg}, 32'd1);
        clearInputs();
        id_valid = 1; id_rs = 8; id_rt = 3;
        #1;
        checkOutput("hazard_rs", {31'b0, hazard_stall_o}, 32'd1);
        id_rs = 9; id_rt = 8;
        #1;
        checkOutput("hazard_rt", {31'b0, hazard_stall_o}, 32'd1);
        id_rt = 4;
        #1;
        checkOutput("hazard_nomatch", {31'b0, hazard_stall_o}, 32'd0);
        id_rt = 8; id_valid = 0;
        #1;
        checkOutput("hazard_id_invalid", {31'b0, hazard_stall_o}, 32'd0);
        id_valid = 1; stall_i = 1; flush_i = 1;
        applyStimulus();
        checkOutput("bubble_valid", {31'b0, ex_valid}, 32'd0);
        checkOutput("bubble_mem_read", {31'b0, ex_mem_read}, 32'd0);
        checkOutput("bubble_hazard", {31'b0, hazard_stall_o}, 32'd0);

        // Stall holds the previously captured instruction
        clearInputs();
        id_valid = 1; id_alu_op = 2'b01; id_rd = 12; id_reg_dst = 1; id_reg_write = 1;
        applyStimulus();
        stall_i = 1; id_alu_op = 2'b11; id_rd = 13; id_valid = 0;
        applyStimulus();
        checkOutput("stall_ctrl", {28'b0, alu_ctrl}, 32'h6);
        checkOutput("stall_wr_reg", {27'b0, ex_wr_reg}, 32'd12);
        checkOutput("stall_valid", {31'b0, ex_valid}, 32'd1);

        // beq then sw with immediate B operand and forwarded store data
        clearInputs();
        id_valid = 1; id_alu_op = 2'b01; id_branch_eq = 1;
        applyStimulus();
        checkOutput("beq_ctrl", {28'b0, alu_ctrl}, 32'h6);
        checkOutput("beq_branch_eq", {31'b0, alu_branch_eq}, 32'd1);
        checkOutput("beq_branch_neq", {31'b0, alu_branch_neq}, 32'd0);
        clearInputs();
        id_valid = 1; id_alu_op = 2'b00; id_alu_src = 1; id_imm = 32'h4; id_mem_write = 1;
        id_rt = 10; id_rt_data = 32'h1234;
        exmem_reg_write = 1; exmem_rd = 10; exmem_result = 32'hCAFE;
        applyStimulus();
        checkOutput("sw_alu_b", alu_b, 32'h4);
        checkOutput("sw_store_data", ex_store_data, 32'hCAFE);
        checkOutput("sw_mem_write", {31'b0, ex_mem_write}, 32'd1);
        checkOutput("sw_branch_eq", {31'b0, alu_branch_eq}, 32'd0);

        // Invalid ID slot captured as a bubble
        clearInputs();
        id_valid = 0; id_branch_neq = 1; id_reg_write = 1; id_mem_write = 1;
        applyStimulus();
        checkOutput("inv_valid", {31'b0, ex_valid}, 32'd0);
        checkOutput("inv_branch_neq", {31'b0, alu_branch_neq}, 32'd0);
        checkOutput("inv_reg_write", {31'b0, ex_reg_write}, 32'd0);
        checkOutput("inv_mem_write", {31'b0, ex_mem_write}, 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
